// File: rtl/pe_op_sequencer.sv
// pe_op_sequencer: command FIFO feeding a PE issue/execute/memory sequencer with done/error reporting.
module pe_op_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int MAC_LAT     = 3,
  parameter int ACT_LAT     = 1,
  parameter int NORM_LAT    = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [31:0]                   cmd_instr_i,
  output logic                          pe_valid_o,
  input  logic                          pe_ready_i,
  output logic [31:0]                   pe_instr_o,
  output logic                          mem_req_o,
  input  logic                          mem_ack_i,
  output logic                          done_o,
  output logic [3:0]                    done_op_o,
  output logic                          err_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, MEM} state_t;
  state_t state;
  logic [31:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [7:0] cnt, timer;
  logic [3:0] op, head_op;
  logic [31:0] head;
  logic legal, push, pop, mem_to;
  assign head = fifo[rd_ptr];
  assign head_op = head[31:28];
  assign legal = head_op != 4'h0 && head_op <= 4'h4;
  assign cmd_ready_o = count < (AW+1)'(FIFO_DEPTH);
  assign push = cmd_valid_i && cmd_ready_o;
  assign pop = state == ISSUE && (!legal || pe_ready_i);
  assign mem_to = timer == 8'(MEM_TIMEOUT - 1);
  assign pe_valid_o = state == ISSUE && legal;
  assign pe_instr_o = pe_valid_o ? head : 32'h0;
  assign mem_req_o = state == MEM;
  assign done_o = (state == EXEC && cnt == 8'h0) || (state == MEM && mem_ack_i);
  // An ack arriving in the final timeout cycle still counts as success.
  assign err_o = (state == ISSUE && !legal) || (state == MEM && !mem_ack_i && mem_to);
  assign done_op_o = (state == ISSUE && !legal) ? head_op : (done_o || err_o) ? op : 4'h0;
  assign busy_o = state != IDLE || count != '0;
  assign fifo_count_o = count;
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= cmd_instr_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cnt <= '0;
      timer <= '0;
      op <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      case (state)
        IDLE: if (count != '0) state <= ISSUE;
        ISSUE:
          if (!legal) state <= IDLE;
          else if (pe_ready_i) begin
            op <= head_op;
            timer <= '0;
            cnt <= head_op == 4'h1 ? 8'(MAC_LAT - 1) : head_op == 4'h2 ? 8'(ACT_LAT - 1) : 8'(NORM_LAT - 1);
            state <= head_op == 4'h4 ? MEM : EXEC;
          end
        EXEC:
          if (cnt == 8'h0) state <= IDLE;
          else cnt <= cnt - 8'h1;
        MEM:
          if (mem_ack_i || mem_to) state <= IDLE;
          else timer <= timer + 8'h1;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_op_sequencer.sv
// tb_pe_op_sequencer: directed and random checks of pe_op_sequencer against a queue-based reference model.
module tb_pe_op_sequencer;
  localparam int DEPTH = 4;
  localparam int TO = 8;
  logic clk = 0, rst_n = 0;
  logic cmd_valid_i = 0, pe_ready_i = 0, mem_ack_i = 0;
  logic [31:0] cmd_instr_i = 0;
  logic cmd_ready_o, pe_valid_o, mem_req_o, done_o, err_o, busy_o;
  logic [31:0] pe_instr_o;
  logic [3:0] done_op_o;
  logic [2:0] fifo_count_o;
  int checks = 0, errors = 0, cyc = 0;
  int n_done, n_err, n_valid, n_mem, first_valid, first_done;
  logic [3:0] last_done_op, last_err_op;
  logic [31:0] q[$];
  int mode = 0, left = 0, waited = 0;
  logic [3:0] mop = 0;
  pe_op_sequencer #(.FIFO_DEPTH(DEPTH), .MAC_LAT(3), .ACT_LAT(1), .NORM_LAT(2), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_instr_i(cmd_instr_i), .pe_valid_o(pe_valid_o), .pe_ready_i(pe_ready_i),
    .pe_instr_o(pe_instr_o), .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .done_o(done_o),
    .done_op_o(done_op_o), .err_o(err_o), .busy_o(busy_o), .fifo_count_o(fifo_count_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic int lat(input logic [3:0] o);
    return o == 4'h1 ? 3 : o == 4'h2 ? 1 : 2;
  endfunction
  task automatic clear_stats();
    n_done = 0; n_err = 0; n_valid = 0; n_mem = 0; first_valid = -1; first_done = -1;
    last_done_op = 0; last_err_op = 0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, cmd_ready_o, 1);
    chk({tag, "_valid"}, pe_valid_o, 0);
    chk({tag, "_instr"}, pe_instr_o, 0);
    chk({tag, "_memreq"}, mem_req_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_op"}, done_op_o, 0);
    chk({tag, "_count"}, fifo_count_o, 0);
  endtask
  task automatic step(input logic cv, input logic [31:0] ci, input logic pr, input logic ma);
    bit has, legal, e_valid, e_done, e_err, push;
    logic [3:0] hop, e_op;
    @(negedge clk);
    cmd_valid_i = cv; cmd_instr_i = ci; pe_ready_i = pr; mem_ack_i = ma;
    #1;
    has = q.size() > 0;
    hop = has ? q[0][31:28] : 4'h0;
    legal = has && hop >= 4'h1 && hop <= 4'h4;
    e_valid = mode == 1 && legal;
    e_done = (mode == 2 && left == 1) || (mode == 3 && ma);
    e_err = (mode == 1 && !legal) || (mode == 3 && !ma && waited == TO);
    e_op = mode == 1 ? hop : mop;
    chk("cmd_ready", cmd_ready_o, q.size() < DEPTH);
    chk("fifo_count", fifo_count_o, q.size());
    chk("pe_valid", pe_valid_o, e_valid);
    chk("pe_instr", pe_instr_o, e_valid ? q[0] : 32'h0);
    chk("mem_req", mem_req_o, mode == 3);
    chk("done", done_o, e_done);
    chk("err", err_o, e_err);
    chk("done_op", done_op_o, (e_done || e_err) ? e_op : 4'h0);
    chk("busy", busy_o, mode != 0 || has);
    chk("done_err_excl", done_o && err_o, 0);
    if (done_o) begin n_done++; last_done_op = done_op_o; if (first_done < 0) first_done = cyc; end
    if (err_o) begin n_err++; last_err_op = done_op_o; end
    if (pe_valid_o) begin n_valid++; if (first_valid < 0) first_valid = cyc; end
    if (mem_req_o) n_mem++;
    push = cv && q.size() < DEPTH;
    case (mode)
      0: if (has) mode = 1;
      1:
        if (!legal) begin void'(q.pop_front()); mode = 0; end
        else if (pr) begin
          mop = hop;
          void'(q.pop_front());
          if (hop == 4'h4) begin mode = 3; waited = 1; end
          else begin mode = 2; left = lat(hop); end
        end
      2: if (left == 1) mode = 0; else left--;
      default: if (ma || waited == TO) mode = 0; else waited++;
    endcase
    if (push) q.push_back(ci);
    @(posedge clk);
    cyc++;
  endtask
  initial begin
    int pc;
    #12;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1;
    clear_stats();
    pc = cyc;
    step(1, 32'h1000_0005, 1, 0);
    repeat (7) step(0, 0, 1, 0);
    chk("mac_valid_lat", first_valid - pc, 2);
    chk("mac_done_lat", first_done - pc, 5);
    chk("mac_done_cnt", n_done, 1);
    chk("mac_done_op", last_done_op, 1);
    clear_stats();
    for (int i = 0; i < 5; i++) step(1, {4'h3, 28'(i)}, 0, 0);
    #1;
    chk("full_count", fifo_count_o, 4);
    chk("full_ready", cmd_ready_o, 0);
    repeat (20) step(0, 0, 1, 0);
    chk("drain_done_cnt", n_done, 4);
    clear_stats();
    pc = cyc;
    step(1, 32'h4000_0000, 1, 0);
    for (int i = 1; i < 10; i++) step(0, 0, 1, i == 6);
    chk("mem_req_cycles", n_mem, 4);
    chk("mem_done_cnt", n_done, 1);
    chk("mem_done_op", last_done_op, 4);
    clear_stats();
    step(1, 32'h4000_0000, 1, 0);
    repeat (14) step(0, 0, 1, 0);
    chk("to_req_cycles", n_mem, TO);
    chk("to_err_cnt", n_err, 1);
    chk("to_err_op", last_err_op, 4);
    chk("to_done_cnt", n_done, 0);
    #1;
    chk("to_idle", busy_o, 0);
    clear_stats();
    step(1, 32'h7000_0000, 1, 0);
    step(1, 32'h2000_0001, 1, 0);
    repeat (8) step(0, 0, 1, 0);
    chk("ill_err_cnt", n_err, 1);
    chk("ill_err_op", last_err_op, 7);
    chk("ill_valid_cnt", n_valid, 1);
    chk("ill_done_cnt", n_done, 1);
    chk("ill_done_op", last_done_op, 2);
    step(1, 32'h1000_0000, 1, 0);
    step(1, 32'h3000_0000, 1, 0);
    step(1, 32'h3000_0001, 1, 0);
    #1;
    chk("pre_rst_count", fifo_count_o, 2);
    chk("pre_rst_busy", busy_o, 1);
    @(negedge clk);
    cmd_valid_i = 0;
    #1 rst_n = 0;
    #1 chk_reset("mid_rst");
    q.delete();
    mode = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    clear_stats();
    repeat (8) step(0, 0, 1, 0);
    chk("post_rst_done", n_done, 0);
    chk("post_rst_err", n_err, 0);
    #1;
    chk("post_rst_count", fifo_count_o, 0);
    repeat (1500) begin
      logic [3:0] o;
      o = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      step($urandom_range(0, 9) < 4, {o, 28'($urandom)}, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
